// File: rtl/rx_frame_dec.sv
// Frame decoder after the 4-lane deskew stage: strips control characters and emits
// 32-bit payload words with byte enables, sop/eop/err markers and debug counters.
module rx_frame_dec #(
    parameter int LNUM      = 4,
    parameter int MAX_BYTES = 1536
) (
    input  logic                i_unif_clk,
    input  logic                i_unif_rst,
    input  logic [8*LNUM-1:0]   i_u_aligned_data,
    input  logic [LNUM-1:0]     i_u_aligned_datak,
    input  logic                i_u_deskew_aligned,
    output logic [31:0]         o_u_data,
    output logic [3:0]          o_u_be,
    output logic                o_u_valid,
    output logic                o_u_sop,
    output logic                o_u_eop,
    output logic                o_u_err,
    output logic [15:0]         o_u_frame_cnt,
    output logic [15:0]         o_u_err_cnt,
    output logic [1:0]          o_u_fsm
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    localparam logic [7:0] CH_S = 8'hFB;
    localparam logic [7:0] CH_T = 8'hFD;

    state_e      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  be_q, be_d;
    logic        valid_q, valid_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d;
    logic [15:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;

    logic [3:0]  is_t, is_idle;
    logic        ctl_found;
    logic [1:0]  ctl_n;
    logic [3:0]  low_mask;
    logic [2:0]  add;
    logic [16:0] sum;
    logic        over;

    always_comb begin
        is_t      = '0;
        is_idle   = '0;
        ctl_found = 1'b0;
        ctl_n     = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            is_t[i]    = i_u_aligned_datak[i] && (i_u_aligned_data[8*i +: 8] == CH_T);
            is_idle[i] = i_u_aligned_datak[i] &&
                         (i_u_aligned_data[8*i +: 8] == 8'h1C ||
                          i_u_aligned_data[8*i +: 8] == 8'hBC ||
                          i_u_aligned_data[8*i +: 8] == 8'h7C);
            if (i_u_aligned_datak[i] && !ctl_found) begin
                ctl_found = 1'b1;
                ctl_n     = 2'(i);
            end
        end
        // Only lanes below the first control character carry payload.
        low_mask = ctl_found ? ((4'b0001 << ctl_n) - 4'b0001) : 4'b1111;
        add      = ctl_found ? {1'b0, ctl_n} : 3'd4;
        sum      = {1'b0, byte_cnt_q} + 17'(add);
        over     = sum > 17'(MAX_BYTES);
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = 1'b0;
        sop_d      = 1'b0;
        eop_d      = 1'b0;
        err_d      = 1'b0;
        be_d       = '0;
        byte_cnt_d = byte_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_u_deskew_aligned && i_u_aligned_datak[0] &&
                    i_u_aligned_data[7:0] == CH_S) begin
                    valid_d    = 1'b1;
                    sop_d      = 1'b1;
                    be_d       = 4'b1110;
                    byte_cnt_d = 16'd3;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                valid_d = 1'b1;
                if (!i_u_deskew_aligned) begin
                    eop_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    be_d       = low_mask;
                    byte_cnt_d = sum[15:0];
                    if (ctl_found) begin
                        eop_d = 1'b1;
                        if (is_t[ctl_n]) begin
                            state_d = ST_IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_DROP;
                        end
                    end
                    // Oversize frames still terminate cleanly if this word held a T.
                    if (over) begin
                        eop_d = 1'b1;
                        err_d = 1'b1;
                        if (!(ctl_found && is_t[ctl_n])) state_d = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (!i_u_deskew_aligned || (|is_t) || (&is_idle)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        for (int unsigned i = 0; i < 4; i++)
            data_d[8*i +: 8] = be_d[i] ? i_u_aligned_data[8*i +: 8] : 8'h00;

        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (eop_d && !err_d && frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
        if (eop_d && err_d && err_cnt_q != 16'hFFFF)    err_cnt_d   = err_cnt_q + 16'd1;
    end

    always_ff @(posedge i_unif_clk or posedge i_unif_rst) begin
        if (i_unif_rst) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            be_q        <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            byte_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            be_q        <= be_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
        end
    end

    assign o_u_data      = data_q;
    assign o_u_be        = be_q;
    assign o_u_valid     = valid_q;
    assign o_u_sop       = sop_q;
    assign o_u_eop       = eop_q;
    assign o_u_err       = err_q;
    assign o_u_frame_cnt = frame_cnt_q;
    assign o_u_err_cnt   = err_cnt_q;
    assign o_u_fsm       = state_q;

endmodule

// File: tb/tb_rx_frame_dec.sv
// Bench for rx_frame_dec: vector tables checked through an expected-output queue,
// plus a MAX_BYTES=16 instance and hand-written reset/saturation sequences.
module tb_rx_frame_dec;

    localparam logic [7:0] S = 8'hFB, T = 8'hFD, E = 8'hFE;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data = '0;
    logic [3:0]  datak = '0;
    logic        aligned = 1'b0;

    logic [31:0] o_u_data, b_data;
    logic [3:0]  o_u_be, b_be;
    logic        o_u_valid, o_u_sop, o_u_eop, o_u_err;
    logic        b_valid, b_sop, b_eop, b_err;
    logic [15:0] o_u_frame_cnt, o_u_err_cnt, b_frame_cnt, b_err_cnt;
    logic [1:0]  o_u_fsm, b_fsm;

    always #5 clk = ~clk;

    rx_frame_dec #(.LNUM(4), .MAX_BYTES(1536)) dut (
        .i_unif_clk(clk), .i_unif_rst(rst),
        .i_u_aligned_data(data), .i_u_aligned_datak(datak), .i_u_deskew_aligned(aligned),
        .o_u_data(o_u_data), .o_u_be(o_u_be), .o_u_valid(o_u_valid), .o_u_sop(o_u_sop),
        .o_u_eop(o_u_eop), .o_u_err(o_u_err), .o_u_frame_cnt(o_u_frame_cnt),
        .o_u_err_cnt(o_u_err_cnt), .o_u_fsm(o_u_fsm));

    rx_frame_dec #(.LNUM(4), .MAX_BYTES(16)) dut16 (
        .i_unif_clk(clk), .i_unif_rst(rst),
        .i_u_aligned_data(data), .i_u_aligned_datak(datak), .i_u_deskew_aligned(aligned),
        .o_u_data(b_data), .o_u_be(b_be), .o_u_valid(b_valid), .o_u_sop(b_sop),
        .o_u_eop(b_eop), .o_u_err(b_err), .o_u_frame_cnt(b_frame_cnt),
        .o_u_err_cnt(b_err_cnt), .o_u_fsm(b_fsm));

    typedef struct {
        string       nm;
        logic        al;
        logic [3:0]  k;
        logic [31:0] d;
        logic        ev, es, ee, eer;
        logic [3:0]  ebe;
        logic [1:0]  efsm;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   nbytes = 0;

    function automatic vec_t mk(string nm, logic al, logic [3:0] k, logic [31:0] d,
                                logic ev, logic es, logic ee, logic eer,
                                logic [3:0] ebe, logic [1:0] efsm);
        vec_t x;
        x.nm = nm; x.al = al; x.k = k; x.d = d;
        x.ev = ev; x.es = es; x.ee = ee; x.eer = eer; x.ebe = ebe; x.efsm = efsm;
        return x;
    endfunction

    function automatic logic [31:0] bmask(logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic chk_out(input vec_t x);
        logic [41:0] got, want;
        got  = {o_u_valid, o_u_sop, o_u_eop, o_u_err, o_u_be, o_u_fsm, o_u_data & bmask(x.ebe)};
        want = {x.ev, x.es, x.ee, x.eer, x.ebe, x.efsm, x.d & bmask(x.ebe)};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got v%b s%b e%b er%b be%b fsm%0d d%h, want v%b s%b e%b er%b be%b fsm%0d d%h",
                     x.nm, o_u_valid, o_u_sop, o_u_eop, o_u_err, o_u_be, o_u_fsm,
                     o_u_data & bmask(x.ebe), x.ev, x.es, x.ee, x.eer, x.ebe, x.efsm,
                     x.d & bmask(x.ebe));
        end
    endtask

    task automatic step(input vec_t x);
        aligned = x.al;
        datak   = x.k;
        data    = x.d;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        chk_out(exp_q.pop_front());
        if (o_u_valid) nbytes += $countones(o_u_be);
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) step(tbl[i]);
        tbl.delete();
    endtask

    task automatic chk16(input string nm, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    task automatic chk_b(input string nm, input logic v, input logic e, input logic er,
                         input logic [3:0] be, input logic [1:0] fsm);
        n_cmp++;
        if ({b_valid, b_eop, b_err, b_be, b_fsm} !== {v, e, er, be, fsm}) begin
            n_bad++;
            $display("FAIL %s: got v%b e%b er%b be%b fsm%0d, want v%b e%b er%b be%b fsm%0d",
                     nm, b_valid, b_eop, b_err, b_be, b_fsm, v, e, er, be, fsm);
        end
    endtask

    task automatic chk_zero(input string nm);
        n_cmp++;
        if ({o_u_data, o_u_be, o_u_valid, o_u_sop, o_u_eop, o_u_err,
             o_u_frame_cnt, o_u_err_cnt, o_u_fsm} !== '0) begin
            n_bad++;
            $display("FAIL %s: got d%h be%b v%b s%b e%b er%b fc%h ec%h fsm%0d, want all zero",
                     nm, o_u_data, o_u_be, o_u_valid, o_u_sop, o_u_eop, o_u_err,
                     o_u_frame_cnt, o_u_err_cnt, o_u_fsm);
        end
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        aligned = 1'b1; datak = 4'hF; data = 32'hBCBCBCBC;
        @(posedge clk);
        #1;
        chk_zero(nm);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset("reset_state");

        // Good frame, T in lane 2 with an E above it that must be ignored.
        nbytes = 0;
        tbl.push_back(mk("t1_sop",  1, 4'b0001, {8'h11, 8'h22, 8'h33, S}, 1, 1, 0, 0, 4'b1110, 1));
        tbl.push_back(mk("t1_d0",   1, 4'b0000, 32'h44556677,            1, 0, 0, 0, 4'b1111, 1));
        tbl.push_back(mk("t1_d1",   1, 4'b0000, 32'h8899AABB,            1, 0, 0, 0, 4'b1111, 1));
        tbl.push_back(mk("t1_eop",  1, 4'b1100, {E, T, 8'h99, 8'h88},    1, 0, 1, 0, 4'b0011, 0));
        tbl.push_back(mk("t1_idle", 1, 4'b1111, 32'hBCBCBCBC,            0, 0, 0, 0, 4'b0000, 0));
        run_tbl();
        chk16("t1_bytes", 16'(nbytes), 16'd13);
        chk16("t1_frame_cnt", o_u_frame_cnt, 16'd1);
        chk16("t1_err_cnt", o_u_err_cnt, 16'd0);

        // Error frame, drop until all-idle, then a normal frame.
        do_reset("reset_t2");
        tbl.push_back(mk("t2_sop",    1, 4'b0001, {8'h01, 8'h02, 8'h03, S},   1, 1, 0, 0, 4'b1110, 1));
        tbl.push_back(mk("t2_d0",     1, 4'b0000, 32'h0A0B0C0D,              1, 0, 0, 0, 4'b1111, 1));
        tbl.push_back(mk("t2_err",    1, 4'b0010, {8'h55, 8'h66, E, 8'h77},   1, 0, 1, 1, 4'b0001, 2));
        tbl.push_back(mk("t2_drop_d", 1, 4'b0000, 32'h12345678,              0, 0, 0, 0, 4'b0000, 2));
        tbl.push_back(mk("t2_drop_s", 1, 4'b0001, {8'h21, 8'h22, 8'h23, S},   0, 0, 0, 0, 4'b0000, 2));
        tbl.push_back(mk("t2_idle",   1, 4'b1111, 32'h1C7CBC1C,              0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(mk("t2_sop2",   1, 4'b0001, {8'hA1, 8'hA2, 8'hA3, S},   1, 1, 0, 0, 4'b1110, 1));
        tbl.push_back(mk("t2_eop2",   1, 4'b0001, {8'h00, 8'h00, 8'h00, T},   1, 0, 1, 0, 4'b0000, 0));
        run_tbl();
        chk16("t2_err_cnt", o_u_err_cnt, 16'd1);
        chk16("t2_frame_cnt", o_u_frame_cnt, 16'd1);

        // Oversize on the MAX_BYTES=16 instance: 3 + 4*4 = 19 > 16 on the fourth data word.
        do_reset("reset_t3");
        step(mk("t3_sop", 1, 4'b0001, {8'h01, 8'h02, 8'h03, S}, 1, 1, 0, 0, 4'b1110, 1));
        chk_b("t3_b_sop", 1, 0, 0, 4'b1110, 1);
        for (int i = 0; i < 3; i++) begin
            step(mk("t3_d", 1, 4'b0000, 32'hC0DE0000 + 32'(i), 1, 0, 0, 0, 4'b1111, 1));
            chk_b("t3_b_d", 1, 0, 0, 4'b1111, 1);
        end
        step(mk("t3_d3", 1, 4'b0000, 32'hFEEDBEEF, 1, 0, 0, 0, 4'b1111, 1));
        chk_b("t3_b_over", 1, 1, 1, 4'b1111, 2);
        chk16("t3_b_err_cnt", b_err_cnt, 16'd1);
        step(mk("t3_t0", 1, 4'b0001, {8'h00, 8'h00, 8'h00, T}, 1, 0, 1, 0, 4'b0000, 0));
        chk_b("t3_b_t_in_drop", 0, 0, 0, 4'b0000, 0);
        chk16("t3_frame_cnt", o_u_frame_cnt, 16'd1);

        // Deskew lost mid-frame, then S while unaligned.
        tbl.push_back(mk("t4_sop",     1, 4'b0001, {8'h01, 8'h02, 8'h03, S}, 1, 1, 0, 0, 4'b1110, 1));
        tbl.push_back(mk("t4_d0",      1, 4'b0000, 32'h31323334,            1, 0, 0, 0, 4'b1111, 1));
        tbl.push_back(mk("t4_unalign", 0, 4'b0000, 32'h41424344,            1, 0, 1, 1, 4'b0000, 0));
        tbl.push_back(mk("t4_s_unal",  0, 4'b0001, {8'h51, 8'h52, 8'h53, S}, 0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(mk("t4_idle",    1, 4'b1111, 32'h7C7C7C7C,            0, 0, 0, 0, 4'b0000, 0));
        run_tbl();
        chk16("t4_err_cnt", o_u_err_cnt, 16'd1);

        // T in lane 0 after a full word, then a back-to-back frame ending with T in lane 3.
        tbl.push_back(mk("t5_sop",  1, 4'b0001, {8'h61, 8'h62, 8'h63, S},   1, 1, 0, 0, 4'b1110, 1));
        tbl.push_back(mk("t5_d0",   1, 4'b0000, 32'h71727374,              1, 0, 0, 0, 4'b1111, 1));
        tbl.push_back(mk("t5_t0",   1, 4'b0001, {8'h00, 8'h00, 8'h00, T},   1, 0, 1, 0, 4'b0000, 0));
        tbl.push_back(mk("t5_sop2", 1, 4'b0001, {8'h81, 8'h82, 8'h83, S},   1, 1, 0, 0, 4'b1110, 1));
        tbl.push_back(mk("t5_d1",   1, 4'b0000, 32'h91929394,              1, 0, 0, 0, 4'b1111, 1));
        tbl.push_back(mk("t5_t3",   1, 4'b1000, {T, 8'h33, 8'h22, 8'h11},   1, 0, 1, 0, 4'b0111, 0));
        run_tbl();
        chk16("t5_frame_cnt", o_u_frame_cnt, 16'd3);

        // Counter saturation from a preloaded value.
        do_reset("reset_t6");
        force dut.frame_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.frame_cnt_q;
        chk16("t6_preload", o_u_frame_cnt, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            step(mk("t6_sop", 1, 4'b0001, {8'h01, 8'h02, 8'h03, S}, 1, 1, 0, 0, 4'b1110, 1));
            step(mk("t6_eop", 1, 4'b0001, {8'h00, 8'h00, 8'h00, T}, 1, 0, 1, 0, 4'b0000, 0));
            chk16("t6_frame_sat", o_u_frame_cnt, 16'hFFFF);
        end

        // Asynchronous reset in the middle of a frame.
        step(mk("t7_sop", 1, 4'b0001, {8'h01, 8'h02, 8'h03, S}, 1, 1, 0, 0, 4'b1110, 1));
        step(mk("t7_d0",  1, 4'b0000, 32'hA5A5A5A5,            1, 0, 0, 0, 4'b1111, 1));
        #2;
        rst = 1'b1;
        #1;
        chk_zero("t7_async_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tbl.push_back(mk("t7_no_eop", 1, 4'b0000, 32'h5A5A5A5A,             0, 0, 0, 0, 4'b0000, 0));
        tbl.push_back(mk("t7_sop2",   1, 4'b0001, {8'h01, 8'h02, 8'h03, S}, 1, 1, 0, 0, 4'b1110, 1));
        tbl.push_back(mk("t7_eop2",   1, 4'b0010, {8'h00, 8'h00, T, 8'hEE}, 1, 0, 1, 0, 4'b0001, 0));
        run_tbl();
        chk16("t7_frame_cnt", o_u_frame_cnt, 16'd1);
        chk16("t7_err_cnt", o_u_err_cnt, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
